byte_unbatcher: RTL

Transmit-side counterpart of the byte batcher. It accepts 128-bit blocks from the AES core and serializes each one into 16 bytes for the UART transmitter, MSB byte first.
- Block-side handshake: valid/ready. Byte-side handshake: valid/ready.
- A one-block holding register lets the AES core deliver the next block while the current one is still being sent.
- Sits between the AES output and uart_tx in the Z-Modem transmit path.

---
 rtl/zmodem_pkg.sv | 15 +
 rtl/byte_unbatcher_if.sv | 32 +++
 rtl/byte_unbatcher.sv | 106 ++++++++++
 3 files changed

// File: rtl/zmodem_pkg.sv
// Shared types and sizes for the Z-Modem AES transmit/receive byte path.
package zmodem_pkg;

   localparam int BYTE_W      = 8;
   localparam int BLOCK_BYTES = 16;
   localparam int BLOCK_BITS  = BLOCK_BYTES * BYTE_W;

   typedef logic [BLOCK_BITS-1:0] block_t;

   typedef enum logic {
      UNB_IDLE,
      UNB_SEND
   } unb_state_e;

endpackage

// File: rtl/byte_unbatcher_if.sv
// Block-side and byte-side valid/ready handshakes of the byte unbatcher.
interface byte_unbatcher_if #(
   parameter int BLOCK_BYTES = 16
);

   logic [BLOCK_BYTES*8-1:0] blk_data;
   logic                     blk_valid;
   logic                     blk_ready;
   logic [7:0]               tx_data;
   logic                     tx_valid;
   logic                     tx_ready;

   // master drives blocks in and consumes bytes; slave is the unbatcher
   modport master (
      output blk_data,
      output blk_valid,
      input  blk_ready,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

   modport slave (
      input  blk_data,
      input  blk_valid,
      output blk_ready,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

endinterface

// File: rtl/byte_unbatcher.sv
// Serializes AES blocks into bytes for uart_tx, MSB byte first, with one
// block of holding so the next block can land while the current one drains.
//
// state    | meaning
// UNB_IDLE | nothing to send, ready for a block
// UNB_SEND | shifting out shift_q; pend_q may hold the next block
module byte_unbatcher #(
   parameter int BLOCK_BYTES = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   byte_unbatcher_if.slave  bus,
   output logic             busy,
   output logic [CNT_W-1:0] blocks_sent
);
   import zmodem_pkg::*;

   localparam int            BW       = BLOCK_BYTES * BYTE_W;
   localparam int            IW       = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES - 1);

   unb_state_e       state_q, state_d;
   logic [BW-1:0]    shift_q, shift_d;
   logic [BW-1:0]    pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] sent_q, sent_d;

   logic blk_acc;
   logic byte_acc;
   logic last_byte;

   assign bus.tx_valid  = (state_q == UNB_SEND);
   assign bus.tx_data   = shift_q[BW-1 -: BYTE_W];
   assign bus.blk_ready = !pend_v_q;
   assign busy          = (state_q == UNB_SEND) | pend_v_q;
   assign blocks_sent   = sent_q;

   assign blk_acc   = bus.blk_valid & bus.blk_ready;
   assign byte_acc  = bus.tx_valid & bus.tx_ready;
   assign last_byte = (cnt_q == LAST_IDX);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      cnt_d    = cnt_q;
      sent_d   = sent_q;
      unique case (state_q)
         UNB_IDLE: begin
            if (blk_acc) begin
               shift_d = bus.blk_data;
               cnt_d   = '0;
               state_d = UNB_SEND;
            end
         end
         UNB_SEND: begin
            if (byte_acc) begin
               if (!last_byte) begin
                  shift_d = shift_q << BYTE_W;
                  cnt_d   = cnt_q + 1'b1;
               end else begin
                  sent_d = sent_q + 1'b1;
                  if (pend_v_q) begin
                     shift_d  = pend_q;
                     pend_v_d = 1'b0;
                     cnt_d    = '0;
                  end else if (blk_acc) begin
                     // new block arrives exactly as the last byte leaves: skip the holding register
                     shift_d = bus.blk_data;
                     cnt_d   = '0;
                  end else begin
                     state_d = UNB_IDLE;
                  end
               end
            end
            if (blk_acc && !(byte_acc && last_byte)) begin
               pend_d   = bus.blk_data;
               pend_v_d = 1'b1;
            end
         end
         default: state_d = UNB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= UNB_IDLE;
         shift_q  <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         cnt_q    <= '0;
         sent_q   <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         cnt_q    <= cnt_d;
         sent_q   <= sent_d;
      end
   end

endmodule
